// File: rtl/mc_mem_sequencer.sv
// Fetch/decode/memory/commit sequencer with per-transfer timeout, bounded retry and sticky error state.
// Requests are levels held until ready; a timed-out request backs off one idle cycle before reissue.
module mc_mem_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRIES    = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt_req,
  input  logic                  err_clr,
  output logic                  imem_req,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_q,
  input  logic                  dec_is_load,
  input  logic                  dec_is_store,
  input  logic                  dec_wb,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [DATA_WIDTH-1:0] load_data_q,
  output logic                  wb_en,
  output logic                  pc_update,
  output logic                  halted,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [CNT_WIDTH-1:0]  retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_COMMIT, S_BACKOFF, S_ERROR, S_HALT
  } state_t;

  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_t                  state_q, state_d;
  logic                    resume_mem_q, resume_mem_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [DATA_WIDTH-1:0]   instr_d, load_d;
  logic [CNT_WIDTH-1:0]    retire_q, retire_d;
  logic [1:0]              err_code_q, err_code_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      resume_mem_q <= 1'b0;
      wait_q       <= '0;
      retry_q      <= '0;
      instr_q      <= '0;
      load_data_q  <= '0;
      retire_q     <= '0;
      err_code_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      resume_mem_q <= resume_mem_d;
      wait_q       <= wait_d;
      retry_q      <= retry_d;
      instr_q      <= instr_d;
      load_data_q  <= load_d;
      retire_q     <= retire_d;
      err_code_q   <= err_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    resume_mem_d = resume_mem_q;
    wait_d       = '0;
    retry_d      = retry_q;
    instr_d      = instr_q;
    load_d       = load_data_q;
    retire_d     = retire_q;
    err_code_d   = err_code_q;
    case (state_q)
      S_IDLE: state_d = halt_req ? S_HALT : S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          retry_d = '0;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d      = retry_q + 1'b1;
            resume_mem_d = 1'b0;
            state_d      = S_BACKOFF;
          end else begin
            err_code_d = 2'b01;
            state_d    = S_ERROR;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: state_d = (dec_is_load || dec_is_store) ? S_MEM : S_COMMIT;
      S_MEM: begin
        if (dmem_ready) begin
          if (dec_is_load) load_d = dmem_rdata;
          state_d = S_COMMIT;
        end else if (wait_q == WAIT_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d      = retry_q + 1'b1;
            resume_mem_d = 1'b1;
            state_d      = S_BACKOFF;
          end else begin
            err_code_d = 2'b10;
            state_d    = S_ERROR;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_COMMIT: begin
        retire_d = retire_q + 1'b1;
        retry_d  = '0;
        state_d  = halt_req ? S_HALT : S_FETCH;
      end
      S_BACKOFF: state_d = resume_mem_q ? S_MEM : S_FETCH;
      S_ERROR: begin
        // A cleared error starts a fresh fetch with its full retry allowance.
        if (err_clr) begin
          err_code_d = 2'b00;
          retry_d    = '0;
          state_d    = S_FETCH;
        end
      end
      S_HALT: if (!halt_req) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req   = (state_q == S_FETCH);
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && dec_is_store;
  assign pc_update  = (state_q == S_COMMIT);
  assign wb_en      = (state_q == S_COMMIT) && dec_wb && !dec_is_store;
  assign halted     = (state_q == S_HALT);
  assign err        = (state_q == S_ERROR);
  assign err_code   = err_code_q;
  assign retire_cnt = retire_q;

endmodule
